multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Moore-style control state machine for the multicycle MIPS datapath. It is the upstream end of the 3-bit ALU_Control interface.
- Decodes opcode and funct from the instruction register and sequences fetch, decode, execute, memory and writeback.
- Drives ALU_Control, operand selects, memory enables and register-file enables.
- ALU_Control encoding is fixed: AND=000, OR=001, ADD=010, SUB=110, SLT=111.

Parameters:
- STATE_W, 4, width of the state register and of the debug state output.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; forces state to FETCH.
- opcode  input  6  instr[31:26], from the instruction register (stable after FETCH).
- funct  input  6  instr[5:0], from the instruction register.
- zero  input  1  ALU zero flag (ALU_result == 0).
- ALU_Control  output  3  ALU operation select.
- ALUSrcA  output  1  0=PC, 1=register A.
- ALUSrcB  output  2  00=register B, 01=constant 4, 10=SignImm, 11=SignImm<<2.
- PCSrc  output  2  00=ALU_result, 01=ALUOut, 10=jump target.
- IorD  output  1  memory address select: 0=PC, 1=ALUOut.
- IRWrite  output  1  instruction register load.
- MemWrite  output  1  data memory write.
- RegDst  output  1  0=rt, 1=rd.
- MemtoReg  output  1  0=ALUOut, 1=memory data.
- RegWrite  output  1  register file write.
- PCEn  output  1  PC load = PCWrite | (Branch & zero).
- state  output  STATE_W  current state, for debug and verification.

Behaviour:
- Reset: asynchronous; state=FETCH immediately. While reset=1, all enables are forced 0 (IRWrite, MemWrite, RegWrite, PCEn), all selects are 0, and ALU_Control=010. Outputs take FETCH values on the first cycle after reset deasserts.
- Outputs decode combinationally from state only. Exceptions: RTYPEEX/RTYPEWB use funct; PCEn in BEQEX uses zero. Signals not listed for a state are 0.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Codes 12-15 are illegal and go to FETCH next cycle with all enables 0.
- Per-state outputs:
  - FETCH: ALUSrcA=0, ALUSrcB=01, ALU_Control=ADD, PCSrc=00, IorD=0, IRWrite=1, PCEn=1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALU_Control=ADD (branch target into ALUOut).
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALU_Control=ADD.
  - MEMRD: IorD=1.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
  - MEMWR: IorD=1, MemWrite=1.
  - RTYPEEX: ALUSrcA=1, ALUSrcB=00, ALU_Control from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT; any other funct gives 010.
  - RTYPEWB: RegDst=1, MemtoReg=0, RegWrite=1 only if funct is one of the five legal codes; otherwise RegWrite=0 (no-op).
  - BEQEX: ALUSrcA=1, ALUSrcB=00, ALU_Control=SUB, PCSrc=01, PCEn=zero.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALU_Control=ADD.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
  - JEX: PCSrc=10, PCEn=1.
- Transitions:
  - FETCH -> DECODE.
  - DECODE by opcode:
    - lw 100011 and sw 101011 -> MEMADR.
    - R-type 000000 -> RTYPEEX.
    - beq 000100 -> BEQEX.
    - addi 001000 -> ADDIEX.
    - j 000010 -> JEX.
    - any other opcode -> FETCH (instruction skipped, no writes).
  - MEMADR -> MEMRD if lw, MEMWR if sw.
  - MEMRD -> MEMWB; RTYPEEX -> RTYPEWB; ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX -> FETCH.
- Latency in cycles, FETCH inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.
- opcode is sampled only in DECODE and MEMADR; funct only in RTYPEEX and RTYPEWB. Changes elsewhere are ignored.
- Reset mid-instruction aborts immediately. No write enable may glitch high during or after reset assertion.

Test Plan:
- Reset asserted during MEMRD -> state=0 within the same cycle, RegWrite/MemWrite/PCEn=0 while reset=1; first post-reset cycle shows IRWrite=1, PCEn=1, ALUSrcB=01.
- opcode=100011 (lw) -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; IorD=1 only in state 3.
- opcode=000100 (beq), zero=1 in BEQEX -> PCEn=1, PCSrc=01, ALU_Control=110; repeat with zero=0 -> PCEn=0; 3 cycles back to FETCH.
- opcode=000000, funct=101010 -> ALU_Control=111 in state 6, RegDst=1, RegWrite=1 in state 7; funct=100101 -> 001; funct=000000 -> ALU_Control=010 and RegWrite=0 in state 7.
- opcode=101011 (sw) -> states 0,1,2,5,0; MemWrite=1 exactly one cycle; RegWrite never asserted.
- opcode=111111 -> states 0,1,0, no enables after FETCH; then opcode=000010 -> JEX with PCSrc=10, PCEn=1.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle MIPS control FSM (master) and its datapath (slave).
// Instruction fields and the zero flag flow in; ALU/mux selects and enables flow out.
interface multicycle_control_fsm_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               zero;
  logic [2:0]         ALU_Control;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         PCSrc;
  logic               IorD;
  logic               IRWrite;
  logic               MemWrite;
  logic               RegDst;
  logic               MemtoReg;
  logic               RegWrite;
  logic               PCEn;
  logic [STATE_W-1:0] state;

  modport master (
    input  opcode, funct, zero,
    output ALU_Control, ALUSrcA, ALUSrcB, PCSrc, IorD, IRWrite, MemWrite,
           RegDst, MemtoReg, RegWrite, PCEn, state
  );

  modport slave (
    output opcode, funct, zero,
    input  ALU_Control, ALUSrcA, ALUSrcB, PCSrc, IorD, IRWrite, MemWrite,
           RegDst, MemtoReg, RegWrite, PCEn, state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback and decodes the current state into ALU_Control, selects and enables.
module multicycle_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = STATE_W'(0),
    S_DECODE  = STATE_W'(1),
    S_MEMADR  = STATE_W'(2),
    S_MEMRD   = STATE_W'(3),
    S_MEMWB   = STATE_W'(4),
    S_MEMWR   = STATE_W'(5),
    S_RTYPEEX = STATE_W'(6),
    S_RTYPEWB = STATE_W'(7),
    S_BEQEX   = STATE_W'(8),
    S_ADDIEX  = STATE_W'(9),
    S_ADDIWB  = STATE_W'(10),
    S_JEX     = STATE_W'(11)
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Returns {legal, alu_op}; unknown funct codes execute as ADD but never write back.
  function automatic logic [3:0] funct_decode(input logic [5:0] f);
    case (f)
      6'b100000: funct_decode = {1'b1, ALU_ADD};
      6'b100010: funct_decode = {1'b1, ALU_SUB};
      6'b100100: funct_decode = {1'b1, ALU_AND};
      6'b100101: funct_decode = {1'b1, ALU_OR};
      6'b101010: funct_decode = {1'b1, ALU_SLT};
      default:   funct_decode = {1'b0, ALU_ADD};
    endcase
  endfunction

  state_t     r_state;
  logic [3:0] w_fdec;
  logic [2:0] w_alu;
  logic       w_srca;
  logic [1:0] w_srcb;
  logic [1:0] w_pcsrc;
  logic       w_iord;
  logic       w_irwrite;
  logic       w_memwrite;
  logic       w_regdst;
  logic       w_memtoreg;
  logic       w_regwrite;
  logic       w_pcen;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:   r_state <= S_DECODE;
        S_DECODE: begin
          case (bus.opcode)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_RTYPE:     r_state <= S_RTYPEEX;
            OP_BEQ:       r_state <= S_BEQEX;
            OP_ADDI:      r_state <= S_ADDIEX;
            OP_J:         r_state <= S_JEX;
            default:      r_state <= S_FETCH;
          endcase
        end
        S_MEMADR: begin
          case (bus.opcode)
            OP_LW:   r_state <= S_MEMRD;
            OP_SW:   r_state <= S_MEMWR;
            default: r_state <= S_FETCH;
          endcase
        end
        S_MEMRD:   r_state <= S_MEMWB;
        S_RTYPEEX: r_state <= S_RTYPEWB;
        S_ADDIEX:  r_state <= S_ADDIWB;
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  // Outputs follow the state alone, except funct in R-type states and zero in BEQEX;
  // reset gates everything so no enable can pulse while it is held.
  always_comb begin
    w_fdec     = funct_decode(bus.funct);
    w_alu      = 3'b000;
    w_srca     = 1'b0;
    w_srcb     = 2'b00;
    w_pcsrc    = 2'b00;
    w_iord     = 1'b0;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_pcen     = 1'b0;
    if (reset) begin
      w_alu = ALU_ADD;
    end else begin
      case (r_state)
        S_FETCH: begin
          w_alu = ALU_ADD; w_srcb = 2'b01; w_irwrite = 1'b1; w_pcen = 1'b1;
        end
        S_DECODE:  begin w_alu = ALU_ADD; w_srcb = 2'b11; end
        S_MEMADR:  begin w_alu = ALU_ADD; w_srca = 1'b1; w_srcb = 2'b10; end
        S_MEMRD:   w_iord = 1'b1;
        S_MEMWB:   begin w_memtoreg = 1'b1; w_regwrite = 1'b1; end
        S_MEMWR:   begin w_iord = 1'b1; w_memwrite = 1'b1; end
        S_RTYPEEX: begin w_alu = w_fdec[2:0]; w_srca = 1'b1; end
        S_RTYPEWB: begin w_regdst = 1'b1; w_regwrite = w_fdec[3]; end
        S_BEQEX: begin
          w_alu = ALU_SUB; w_srca = 1'b1; w_pcsrc = 2'b01; w_pcen = bus.zero;
        end
        S_ADDIEX:  begin w_alu = ALU_ADD; w_srca = 1'b1; w_srcb = 2'b10; end
        S_ADDIWB:  w_regwrite = 1'b1;
        S_JEX:     begin w_pcsrc = 2'b10; w_pcen = 1'b1; end
        default: ;
      endcase
    end
  end

  assign bus.ALU_Control = w_alu;
  assign bus.ALUSrcA     = w_srca;
  assign bus.ALUSrcB     = w_srcb;
  assign bus.PCSrc       = w_pcsrc;
  assign bus.IorD        = w_iord;
  assign bus.IRWrite     = w_irwrite;
  assign bus.MemWrite    = w_memwrite;
  assign bus.RegDst      = w_regdst;
  assign bus.MemtoReg    = w_memtoreg;
  assign bus.RegWrite    = w_regwrite;
  assign bus.PCEn        = w_pcen;
  assign bus.state       = r_state;

endmodule
